// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with occupancy count, programmable almost-full/almost-empty
// flags, optional first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo_ctl #(
   parameter int unsigned DW        = 8,
   parameter int unsigned AW        = 4,
   parameter int unsigned AFULL_TH  = 12,
   parameter int unsigned AEMPTY_TH = 2,
   parameter int unsigned FWFT      = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic [DW-1:0] wdata,
   input  logic          rd,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          wfull,
   output logic          rempty,
   output logic          afull,
   output logic          aempty,
   output logic [AW:0]   count,
   input  logic          flush,
   input  logic          err_clr,
   output logic          overflow,
   output logic          underflow
);

   localparam int unsigned DEPTH     = 1 << AW;
   localparam logic [AW:0] DepthCnt  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AfullCnt  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AemptyCnt = (AW+1)'(AEMPTY_TH);

   // Out-of-range thresholds stop elaboration rather than yielding flags that never toggle.
   if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $fatal(1, "sync_fifo_ctl: AFULL_TH=%0d outside 1..%0d", AFULL_TH, DEPTH);
   end
   if (AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $fatal(1, "sync_fifo_ctl: AEMPTY_TH=%0d outside 0..%0d", AEMPTY_TH, DEPTH - 1);
   end

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q, afull_q, aempty_q;
   logic          ovf_q, udf_q;
   logic          wacc, racc;

   always_comb begin
      wacc  = wr & ~full_q;
      racc  = rd & ~empty_q;
      cnt_d = cnt_q + {{AW{1'b0}}, wacc} - {{AW{1'b0}}, racc};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else if (flush) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         if (wacc) wptr_q <= wptr_q + 1'b1;
         if (racc) rptr_q <= rptr_q + 1'b1;
         cnt_q    <= cnt_d;
         // Flags track the post-edge count so they agree with count on every cycle.
         full_q   <= (cnt_d == DepthCnt);
         empty_q  <= (cnt_d == '0);
         afull_q  <= (cnt_d >= AfullCnt);
         aempty_q <= (cnt_d <= AemptyCnt);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && wacc) mem[wptr_q] <= wdata;
   end

   // A new error in the same cycle as err_clr takes precedence over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (err_clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end
         if (!flush && wr && full_q)  ovf_q <= 1'b1;
         if (!flush && rd && empty_q) udf_q <= 1'b1;
      end
   end

   if (FWFT != 0) begin : g_fwft
      assign rdata  = mem[rptr_q];
      assign rvalid = ~empty_q;
   end else begin : g_std
      logic [DW-1:0] rdata_q;
      logic          rvalid_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else if (flush) begin
            rvalid_q <= 1'b0;
         end else begin
            rvalid_q <= racc;
            if (racc) rdata_q <= mem[rptr_q];
         end
      end
      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
   end

   assign wfull     = full_q;
   assign rempty    = empty_q;
   assign afull     = afull_q;
   assign aempty    = aempty_q;
   assign count     = cnt_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

endmodule
